window_watchdog_ctrl: RTL and testbench

Sequencing controller for the windowed watchdog. It consumes the configuration outputs FWLEN, SWLEN, RST_LMT, WDSRVC and INIT, and runs the closed-window/open-window timing FSM. It detects early and late service, generates the system reset pulse, and keeps a lifetime fault count that latches a permanent lockout at RST_LMT. It sits between the configuration register block and the system reset tree.

---
 rtl/window_watchdog_ctrl.sv | 164 ++++++++++++++++
 tb/tb_window_watchdog_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/window_watchdog_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_watchdog_ctrl: closed/open window watchdog sequencer, reset pulse,|
// | fault counter and lockout. Option macro: WWDT_EARLY_WARN_EN (EWARN).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module window_watchdog_ctrl #(
  parameter int TICK_DIV  = 16,
  parameter int RST_PULSE = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INIT,
  input  logic       WDSRVC,
  input  logic [7:0] FWLEN,
  input  logic [7:0] SWLEN,
  input  logic [7:0] RST_LMT,
  output logic       WDRST,
  output logic       WIN_OPEN,
  output logic [1:0] STATUS,
  output logic [7:0] FAULT_CNT,
  output logic       EWARN
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] PULSE_LAST = RW'(RST_PULSE - 1);

  typedef enum logic [2:0] {
    S_DISABLED   = 3'd0,
    S_FIRST_WIN  = 3'd1,
    S_SECOND_WIN = 3'd2,
    S_FAULT_RST  = 3'd3,
    S_LOCKED     = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [7:0]    tick_cnt;
  logic [7:0]    win_len;
  logic [RW-1:0] pulse_cnt;
  logic          srvc_q;
  logic [1:0]    status_nxt;
  logic [7:0]    len_sel;
  logic [7:0]    len_nxt;
  logic          srvc_evt;
  logic          tick;
  logic          win_done;
  logic          entering;

  assign srvc_evt = WDSRVC & ~srvc_q;
  assign tick     = (presc == PRESC_LAST);
  assign win_done = tick && (({1'b0, tick_cnt} + 9'd1) >= {1'b0, win_len});
  assign entering = (state_nxt != state);
  // Length is captured for whichever window is being entered; zero means one tick.
  assign len_sel  = (state_nxt == S_FIRST_WIN) ? FWLEN : SWLEN;
  assign len_nxt  = (len_sel == 8'd0) ? 8'd1 : len_sel;

  always_comb begin
    state_nxt  = state;
    status_nxt = STATUS;
    case (state)
      S_DISABLED: begin
        if (INIT) state_nxt = S_FIRST_WIN;
        else      status_nxt = 2'b00;
      end
      S_FIRST_WIN: begin
        if (!INIT) begin
          state_nxt  = S_DISABLED;
          status_nxt = 2'b00;
        end else if (srvc_evt) begin
          state_nxt  = S_FAULT_RST;
          status_nxt = 2'b01;
        end else if (win_done) begin
          state_nxt  = S_SECOND_WIN;
        end
      end
      S_SECOND_WIN: begin
        if (!INIT) begin
          state_nxt  = S_DISABLED;
          status_nxt = 2'b00;
        end else if (srvc_evt) begin
          state_nxt  = S_FIRST_WIN;
        end else if (win_done) begin
          state_nxt  = S_FAULT_RST;
          status_nxt = 2'b10;
        end
      end
      S_FAULT_RST: begin
        if (pulse_cnt == PULSE_LAST) begin
          if ((RST_LMT != 8'd0) && (FAULT_CNT >= RST_LMT)) begin
            state_nxt  = S_LOCKED;
            status_nxt = 2'b11;
          end else if (INIT) begin
            state_nxt  = S_FIRST_WIN;
          end else begin
            state_nxt  = S_DISABLED;
          end
        end
      end
      S_LOCKED: begin
        state_nxt = S_LOCKED;
      end
      default: begin
        state_nxt  = S_DISABLED;
        status_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_DISABLED;
      presc     <= '0;
      tick_cnt  <= 8'd0;
      win_len   <= 8'd1;
      pulse_cnt <= '0;
      srvc_q    <= 1'b0;
      WDRST     <= 1'b0;
      WIN_OPEN  <= 1'b0;
      STATUS    <= 2'b00;
      FAULT_CNT <= 8'd0;
    end else begin
      state  <= state_nxt;
      srvc_q <= WDSRVC;
      if (entering) begin
        presc     <= '0;
        tick_cnt  <= 8'd0;
        pulse_cnt <= '0;
        win_len   <= len_nxt;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) tick_cnt <= tick_cnt + 8'd1;
        if ((state == S_FAULT_RST) && (pulse_cnt != PULSE_LAST))
          pulse_cnt <= pulse_cnt + 1'b1;
      end
      if (entering && (state_nxt == S_FAULT_RST) && (FAULT_CNT != 8'hFF))
        FAULT_CNT <= FAULT_CNT + 8'd1;
      WDRST    <= (state_nxt == S_FAULT_RST) || (state_nxt == S_LOCKED);
      WIN_OPEN <= (state_nxt == S_SECOND_WIN);
      STATUS   <= status_nxt;
    end
  end

`ifdef WWDT_EARLY_WARN_EN
  logic ewarn_hit;

  // Staying in the open window excludes both a service and an INIT drop on this cycle.
  assign ewarn_hit = (state == S_SECOND_WIN) && (state_nxt == S_SECOND_WIN) && tick &&
                     (win_len > 8'd1) && ((tick_cnt + 8'd1) == (win_len - 8'd1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) EWARN <= 1'b0;
    else     EWARN <= ewarn_hit;
  end
`else
  assign EWARN = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_watchdog_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for window_watchdog_ctrl: expected output words are queued as
// inputs are driven and compared one clock later. TICK_DIV=2, RST_PULSE=4.
module tb_window_watchdog_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       INIT;
  logic       WDSRVC;
  logic [7:0] FWLEN;
  logic [7:0] SWLEN;
  logic [7:0] RST_LMT;
  logic       WDRST;
  logic       WIN_OPEN;
  logic [1:0] STATUS;
  logic [7:0] FAULT_CNT;
  logic       EWARN;

  int total = 0;
  int bad   = 0;
  logic [12:0] sb_q[$];

`ifdef WWDT_EARLY_WARN_EN
  localparam bit EW_ON = 1'b1;
`else
  localparam bit EW_ON = 1'b0;
`endif

  window_watchdog_ctrl #(.TICK_DIV(2), .RST_PULSE(4)) dut (
    .CLK(CLK), .RST(RST), .INIT(INIT), .WDSRVC(WDSRVC),
    .FWLEN(FWLEN), .SWLEN(SWLEN), .RST_LMT(RST_LMT),
    .WDRST(WDRST), .WIN_OPEN(WIN_OPEN), .STATUS(STATUS),
    .FAULT_CNT(FAULT_CNT), .EWARN(EWARN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [12:0] ev(input logic w, input logic o, input logic [1:0] s,
                                     input logic [7:0] f, input logic e);
    return {w, o, s, f, e};
  endfunction

  function automatic logic [12:0] obs();
    return {WDRST, WIN_OPEN, STATUS, FAULT_CNT, EWARN};
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got {rst,open,st,cnt,ew}=%b want=%b", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge, then score.
  task automatic step(input logic init_v, input logic srv_v, input logic [12:0] exp_v,
                      input string tag);
    logic [12:0] want;
    INIT   = init_v;
    WDSRVC = srv_v;
    sb_q.push_back(exp_v);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      want = sb_q.pop_front();
      chk(tag, obs(), want);
    end
  endtask

  task automatic async_reset(input string tag);
    #2 RST = 1'b1;
    #1 chk(tag, obs(), ev(0, 0, 2'b00, 8'd0, 0));
    INIT   = 1'b0;
    WDSRVC = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; INIT = 1'b0; WDSRVC = 1'b0;
    FWLEN = 8'd3; SWLEN = 8'd4; RST_LMT = 8'd0;
    #12;
    chk("reset state", obs(), ev(0, 0, 2'b00, 8'd0, 0));
    @(negedge CLK);
    RST = 1'b0;
    step(0, 0, ev(0, 0, 2'b00, 8'd0, 0), "idle after reset");

    // Service inside the open window
    step(1, 0, ev(0, 0, 2'b00, 8'd0, 0), "s2 c0");
    for (int c = 1; c <= 12; c++)
      step(1, (c - 1) >= 8 && (c - 1) <= 10, ev(0, c >= 6 && c <= 8, 2'b00, 8'd0, 0),
           $sformatf("s2 c%0d", c));
    step(0, 0, ev(0, 0, 2'b00, 8'd0, 0), "s2 disable");

    // Early service in the closed window
    step(1, 0, ev(0, 0, 2'b00, 8'd0, 0), "s3 c0");
    for (int c = 1; c <= 14; c++)
      step((c - 1) != 13, (c - 1) >= 2 && (c - 1) <= 3,
           ev(c >= 3 && c <= 6, c == 13, (c >= 3 && c <= 13) ? 2'b01 : 2'b00,
              (c >= 3) ? 8'd1 : 8'd0, 0),
           $sformatf("s3 c%0d", c));

    // Timeout, INIT dropped during the reset pulse
    step(1, 0, ev(0, 0, 2'b00, 8'd1, 0), "s4 c0");
    for (int c = 1; c <= 19; c++)
      step((c - 1) < 15, 0,
           ev(c >= 14 && c <= 17, c >= 6 && c <= 13, (c >= 14 && c <= 18) ? 2'b10 : 2'b00,
              (c >= 14) ? 8'd2 : 8'd1, EW_ON && c == 12),
           $sformatf("s4 c%0d", c));

    // Async reset mid-operation, then idle with INIT low
    step(1, 0, ev(0, 0, 2'b00, 8'd2, 0), "s1 c0");
    for (int c = 1; c <= 7; c++)
      step(1, 0, ev(0, c >= 6, 2'b00, 8'd2, 0), $sformatf("s1 c%0d", c));
    async_reset("s1 async clear");
    for (int c = 0; c < 20; c++)
      step(0, 0, ev(0, 0, 2'b00, 8'd0, 0), $sformatf("s1 idle%0d", c));

    // Lockout after two timeouts
    RST_LMT = 8'd2;
    step(1, 0, ev(0, 0, 2'b00, 8'd0, 0), "s5 c0");
    for (int c = 1; c <= 35; c++)
      step(1, 0,
           ev((c >= 14 && c <= 17) || (c >= 32 && c <= 35),
              (c >= 6 && c <= 13) || (c >= 24 && c <= 31),
              (c >= 14) ? 2'b10 : 2'b00,
              (c >= 32) ? 8'd2 : ((c >= 14) ? 8'd1 : 8'd0),
              EW_ON && (c == 12 || c == 30)),
           $sformatf("s5 c%0d", c));
    for (int c = 36; c <= 45; c++)
      step((c - 1) == 35 ? 1'b1 : c[0], (c - 1) == 35 ? 1'b0 : c[1],
           ev(1, 0, 2'b11, 8'd2, 0), $sformatf("s5 lock c%0d", c));
    async_reset("s5 async clear");
    step(0, 0, ev(0, 0, 2'b00, 8'd0, 0), "s5 after reset");

    // Zero-length windows, service on the timeout cycle, then a real timeout
    RST_LMT = 8'd0; FWLEN = 8'd0; SWLEN = 8'd0;
    step(1, 0, ev(0, 0, 2'b00, 8'd0, 0), "s6 c0");
    for (int c = 1; c <= 12; c++)
      step(1, (c - 1) >= 3 && (c - 1) <= 4,
           ev(c >= 8 && c <= 11, c == 2 || c == 3 || c == 6 || c == 7,
              (c >= 8) ? 2'b10 : 2'b00, (c >= 8) ? 8'd1 : 8'd0, 0),
           $sformatf("s6 c%0d", c));

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: %0d entries left", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
